// File: rtl/data_memory_ctrl_if.sv
// Cache-to-main-memory request/response bundle.
//   master: cache controller side (drives requests, address, write data)
//   slave : memory controller side (drives busy, refill block, done/valid pulses)
interface data_memory_ctrl_if #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 4
);
  logic                              mem_rd_req;
  logic                              mem_wr_req;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_wr_data;
  logic                              mem_busy;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_rd_data;
  logic                              mem_rd_valid;
  logic                              mem_wr_done;

  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
    input  mem_busy, mem_rd_data, mem_rd_valid, mem_wr_done
  );

  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
    output mem_busy, mem_rd_data, mem_rd_valid, mem_wr_done
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Main-memory stage behind the cache: 2^ADDR_WIDTH x DATA_WIDTH backing array
// with a fixed access latency, block refills and word write-through stores.
// A write and read requested together are serviced write-first, read queued.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : data_memory_ctrl_if.slave (requests in; busy, refill block,
//          rd_valid / wr_done pulses out)
module data_memory_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BLOCK_WORDS    = 4,
  parameter int unsigned ACCESS_LATENCY = 4
) (
  input logic               clk,
  input logic               rst,
  data_memory_ctrl_if.slave bus
);

  localparam int unsigned OFS   = $clog2(BLOCK_WORDS);
  localparam int unsigned BLK_W = ADDR_WIDTH - OFS;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            rd_pending_q, rd_pending_d;
  logic                            busy_q;
  logic                            wr_done_q, wr_done_d;
  logic                            rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0]           wr_addr_q;
  logic [DATA_WIDTH-1:0]           wr_data_q;
  logic [BLK_W-1:0]                rd_blk_q;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] rd_data_q;
  logic                            lat_wr_c, lat_rd_c, mem_we_c, load_rd_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Next-state, counter and pulse decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_pending_d = rd_pending_q;
    wr_done_d    = 1'b0;
    rd_valid_d   = 1'b0;
    lat_wr_c     = 1'b0;
    lat_rd_c     = 1'b0;
    mem_we_c     = 1'b0;
    load_rd_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!busy_q) begin
          if (bus.mem_wr_req) begin
            state_d  = WR_WAIT;
            cnt_d    = CNT_LOAD;
            lat_wr_c = 1'b1;
            if (bus.mem_rd_req) begin
              rd_pending_d = 1'b1;
              lat_rd_c     = 1'b1;
            end
          end else if (bus.mem_rd_req) begin
            state_d  = RD_WAIT;
            cnt_d    = CNT_LOAD;
            lat_rd_c = 1'b1;
          end
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          mem_we_c  = 1'b1;
          wr_done_d = 1'b1;
          if (rd_pending_q) begin
            // queued read starts only after the commit, so it sees the new word
            rd_pending_d = 1'b0;
            cnt_d        = CNT_LOAD;
            state_d      = RD_WAIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          load_rd_c  = 1'b1;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      busy_q       <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_blk_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pending_q <= rd_pending_d;
      busy_q       <= (state_d != IDLE) || rd_pending_d;
      wr_done_q    <= wr_done_d;
      rd_valid_q   <= rd_valid_d;
      if (lat_wr_c) begin
        wr_addr_q <= bus.mem_addr;
        wr_data_q <= bus.mem_wr_data;
      end
      if (lat_rd_c) rd_blk_q <= bus.mem_addr[ADDR_WIDTH-1:OFS];
      // whole block captured on one edge, so no partial data is ever visible
      if (load_rd_c) begin
        for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
          rd_data_q[k*DATA_WIDTH +: DATA_WIDTH] <= mem[{rd_blk_q, OFS'(k)}];
        end
      end
    end
  end

  // Backing array: deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[wr_addr_q] <= wr_data_q;
  end

  assign bus.mem_busy     = busy_q;
  assign bus.mem_wr_done  = wr_done_q;
  assign bus.mem_rd_valid = rd_valid_q;
  assign bus.mem_rd_data  = rd_data_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: table of request vectors with expected pulse
// latencies, a block scoreboard fed from a word model, and hand-written
// sequences for reset abort, busy rejection and ACCESS_LATENCY=1.
module tb_data_memory_ctrl;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;
  localparam int unsigned OFS = 2;
  localparam int unsigned L   = 4;
  localparam int unsigned NW  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_memory_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) bus  ();
  data_memory_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) bus1 ();

  data_memory_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW),
                     .ACCESS_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));
  data_memory_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW),
                     .ACCESS_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [BW*DW-1:0] data;
    logic [BW*DW-1:0] mask;
  } exp_t;

  typedef struct {
    bit             wr;
    bit             rd;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    int             wr_lat;   // expected edges from acceptance to wr_done, 0 = none
    int             rd_lat;   // expected edges from acceptance to rd_valid, 0 = none
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            wr_done_seen = 0;
  exp_t          sb[$];
  logic [DW-1:0] model [NW];
  bit            known [NW];

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [BW*DW-1:0] act,
                           input logic [BW*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%032h expected 0x%032h", name, act, exp);
    end
  endtask

  function automatic exp_t expect_block(input logic [AW-1:0] addr);
    exp_t          e;
    logic [AW-1:0] idx;
    e.data = '0;
    e.mask = '0;
    for (int unsigned k = 0; k < BW; k++) begin
      idx = {addr[AW-1:OFS], OFS'(k)};
      if (known[idx]) begin
        e.data[k*DW +: DW] = model[idx];
        e.mask[k*DW +: DW] = '1;
      end
    end
    return e;
  endfunction

  // Scoreboard consumer: every rd_valid pops one expected block
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.mem_wr_done) wr_done_seen++;
    if (bus.mem_rd_valid) begin
      if (sb.size() == 0) begin
        check_int("rd_valid_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check_blk("rd_data", bus.mem_rd_data & e.mask, e.data & e.mask);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string name);
    int wr_at, rd_at;
    bit busy_ok, done;
    @(negedge clk);
    check_int({name, "_idle_before"}, int'(bus.mem_busy), 0);
    bus.mem_addr    = v.addr;
    bus.mem_wr_data = v.wdata;
    bus.mem_wr_req  = v.wr;
    bus.mem_rd_req  = v.rd;
    if (v.wr) begin
      model[v.addr] = v.wdata;
      known[v.addr] = 1'b1;
    end
    if (v.rd) sb.push_back(expect_block(v.addr));
    @(posedge clk);
    #1;
    bus.mem_wr_req = 1'b0;
    bus.mem_rd_req = 1'b0;
    busy_ok = bus.mem_busy;
    wr_at = 0;
    rd_at = 0;
    done  = 1'b0;
    for (int cyc = 1; cyc <= 4 * int'(L) + 8; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.mem_wr_done && wr_at == 0) wr_at = cyc;
      if (bus.mem_rd_valid && rd_at == 0) rd_at = cyc;
      done = (v.wr_lat == 0 || wr_at != 0) && (v.rd_lat == 0 || rd_at != 0);
      if (done) break;
      if (!bus.mem_busy) busy_ok = 1'b0;
    end
    check_int({name, "_wr_lat"}, wr_at, v.wr_lat);
    check_int({name, "_rd_lat"}, rd_at, v.rd_lat);
    check_int({name, "_busy_hold"}, int'(busy_ok), 1);
    check_int({name, "_busy_at_pulse"}, int'(bus.mem_busy), 0);
  endtask

  vec_t vecs[13];
  vec_t v;
  int   base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NW); i++) known[i] = 1'b0;
    bus.mem_rd_req = 1'b0;  bus.mem_wr_req = 1'b0;
    bus.mem_addr = '0;      bus.mem_wr_data = '0;
    bus1.mem_rd_req = 1'b0; bus1.mem_wr_req = 1'b0;
    bus1.mem_addr = '0;     bus1.mem_wr_data = '0;

    //               wr rd addr    data   wr_lat rd_lat
    vecs[0]  = '{1, 0, 10'h389, 32'd16,  L,    0};
    vecs[1]  = '{1, 0, 10'h38A, 32'd8,   L,    0};
    vecs[2]  = '{1, 0, 10'h388, 32'd4,   L,    0};
    vecs[3]  = '{1, 0, 10'h38B, 32'd2,   L,    0};
    vecs[4]  = '{0, 1, 10'h38B, 32'd0,   0,    L};
    vecs[5]  = '{1, 0, 10'h38A, 32'd120, L,    0};
    vecs[6]  = '{1, 1, 10'h389, 32'd100, L,    2*L};
    vecs[7]  = '{1, 0, 10'h2C9, 32'd7,   L,    0};
    vecs[8]  = '{1, 0, 10'h289, 32'd200, L,    0};
    vecs[9]  = '{1, 0, 10'h28A, 32'd220, L,    0};
    vecs[10] = '{0, 1, 10'h388, 32'd0,   0,    L};
    vecs[11] = '{0, 1, 10'h288, 32'd0,   0,    L};
    vecs[12] = '{0, 1, 10'h38A, 32'd0,   0,    L};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_busy", int'(bus.mem_busy), 0);
    check_int("rst_rd_valid", int'(bus.mem_rd_valid), 0);
    check_int("rst_wr_done", int'(bus.mem_wr_done), 0);
    check_blk("rst_rd_data", bus.mem_rd_data, '0);
    @(negedge clk);
    rst = 1'b1;

    // Known word at 0x389 so an aborted write is observable
    v = '{1, 0, 10'h389, 32'h55, L, 0};
    run_vec(v, "pre_wr");

    // Reset in mid-WR_WAIT aborts the write of 0x10 to 0x389
    @(negedge clk);
    bus.mem_addr = 10'h389; bus.mem_wr_data = 32'h10; bus.mem_wr_req = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_wr_req = 1'b0;
    @(posedge clk);
    #3;
    check_int("abort_busy_before", int'(bus.mem_busy), 1);
    rst = 1'b0;
    #1;
    check_int("abort_busy", int'(bus.mem_busy), 0);
    check_int("abort_wr_done", int'(bus.mem_wr_done), 0);
    check_int("abort_rd_valid", int'(bus.mem_rd_valid), 0);
    check_blk("abort_rd_data", bus.mem_rd_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    base = wr_done_seen;
    repeat (3 * L) @(posedge clk);
    #1;
    check_int("abort_no_wr_done", wr_done_seen - base, 0);
    v = '{0, 1, 10'h38A, 32'd0, 0, L};
    run_vec(v, "abort_rd");

    // Main vector table
    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Request while busy is ignored
    base = wr_done_seen;
    @(negedge clk);
    bus.mem_addr = 10'h100; bus.mem_wr_data = 32'd1; bus.mem_wr_req = 1'b1;
    model[10'h100] = 32'd1; known[10'h100] = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_wr_req = 1'b0;
    @(negedge clk);
    check_int("ign_busy_seen", int'(bus.mem_busy), 1);
    bus.mem_addr = 10'h2C9; bus.mem_wr_data = 32'd200; bus.mem_wr_req = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_wr_req = 1'b0;
    repeat (3 * L) @(posedge clk);
    #1;
    check_int("ign_wr_done_count", wr_done_seen - base, 1);
    v = '{0, 1, 10'h2C8, 32'd0, 0, L};
    run_vec(v, "ign_rd");

    // ACCESS_LATENCY = 1: write, then reads at E0 and E0+2
    @(negedge clk);
    bus1.mem_addr = 10'h005; bus1.mem_wr_data = 32'd9; bus1.mem_wr_req = 1'b1;
    @(posedge clk);
    #1;
    bus1.mem_wr_req = 1'b0;
    check_int("l1_wr_busy", int'(bus1.mem_busy), 1);
    @(posedge clk);
    #1;
    check_int("l1_wr_done", int'(bus1.mem_wr_done), 1);
    check_int("l1_wr_busy_at_pulse", int'(bus1.mem_busy), 0);
    @(negedge clk);
    bus1.mem_addr = 10'h004; bus1.mem_rd_req = 1'b1;
    @(posedge clk);
    #1;
    bus1.mem_rd_req = 1'b0;
    check_int("l1_rd0_busy", int'(bus1.mem_busy), 1);
    check_int("l1_rd0_not_yet", int'(bus1.mem_rd_valid), 0);
    @(posedge clk);
    #1;
    check_int("l1_rd0_valid", int'(bus1.mem_rd_valid), 1);
    check_int("l1_rd0_word1", int'(bus1.mem_rd_data[DW +: DW]), 9);
    @(negedge clk);
    bus1.mem_addr = 10'h008; bus1.mem_rd_req = 1'b1;
    @(posedge clk);
    #1;
    bus1.mem_rd_req = 1'b0;
    check_int("l1_rd1_pulse_ended", int'(bus1.mem_rd_valid), 0);
    check_int("l1_rd1_busy", int'(bus1.mem_busy), 1);
    @(posedge clk);
    #1;
    check_int("l1_rd1_valid", int'(bus1.mem_rd_valid), 1);
    @(posedge clk);
    #1;
    check_int("l1_rd1_single_pulse", int'(bus1.mem_rd_valid), 0);

    repeat (2) @(posedge clk);
    #1;
    check_int("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Main-memory stage directly downstream of `cache_Memory_top`: it serves the cache controller's block refills on read misses and its write-through word stores. It holds the 1024 x 32-bit backing array, models a fixed multi-cycle access latency, and drives the busy indication from which the cache derives `stall`. It accepts one write and one read in the same cycle by queuing the read behind the write.

## Interface
- `ADDR_WIDTH`, 10, word address width (word-addressed array of 2^ADDR_WIDTH words).
- `DATA_WIDTH`, 32, word width.
- `BLOCK_WORDS`, 4, words per cache block (power of two); offset width OFS = log2(BLOCK_WORDS).
- `ACCESS_LATENCY`, 4, cycles from acceptance to completion; legal range >= 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_rd_req` in 1: block read request, single-cycle pulse.
- `mem_wr_req` in 1: word write request, single-cycle pulse.
- `mem_addr` in ADDR_WIDTH: word address. Reads ignore the low OFS bits.
- `mem_wr_data` in DATA_WIDTH: write word, sampled only on write acceptance.
- `mem_busy` out 1: controller not accepting new requests.
- `mem_rd_data` out BLOCK_WORDS*DATA_WIDTH: refill block. Word at offset k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
- `mem_rd_valid` out 1: one-cycle pulse when `mem_rd_data` is updated.
- `mem_wr_done` out 1: one-cycle pulse when a write has been committed to the array.

## Operation
- **States:**
  - IDLE: no access in progress.
  - WR_WAIT: a write is in progress.
  - RD_WAIT: a read is in progress.
- **Acceptance:**
  - A request is accepted at a rising edge where it is high and `mem_busy` = 0.
  - A request presented while `mem_busy` = 1 is ignored. The requester re-issues it.
- **Latching at acceptance:**
  - Address, write data and request type are registered.
  - A down-counter loads ACCESS_LATENCY-1.
- **IDLE transitions:**
  - `mem_wr_req` only: go to WR_WAIT.
  - `mem_rd_req` only: go to RD_WAIT.
  - Both high: go to WR_WAIT and set `rd_pending`, latching the read address in a separate register.
- **WR_WAIT:**
  - The counter decrements each cycle.
  - At the edge where it is 0, the array word at the latched address is written and `mem_wr_done` is registered high.
  - If `rd_pending` = 1: clear it, reload the counter and go to RD_WAIT.
  - Otherwise: go to IDLE.
- **RD_WAIT:**
  - At the edge where the counter is 0, all BLOCK_WORDS words of block `addr[ADDR_WIDTH-1:OFS]` are loaded into `mem_rd_data`.
  - `mem_rd_valid` is registered high and the state goes to IDLE.
- **Write-then-read ordering:** the queued read always observes the value committed by the preceding write, including when both target the same block.
- **Array contents:** not cleared by reset, and undefined at power-up.
- **`mem_busy`:** equals (state != IDLE) || `rd_pending`.

## Timing
- **Reset values** (all outputs 0, immediately on `rst` low, asynchronously):
  - `mem_busy` 0, `mem_rd_valid` 0, `mem_wr_done` 0, `mem_rd_data` 0.
  - state IDLE, `rd_pending` 0, counter 0.
- **Single access:**
  - Accepted at edge E0.
  - `mem_busy` is 1 from E0 up to edge E0+ACCESS_LATENCY.
  - The done/valid pulse is high for exactly the cycle after E0+ACCESS_LATENCY, with `mem_busy` = 0 in that cycle.
  - The next request is accepted at E0+ACCESS_LATENCY+1 at the earliest.
- **Combined write+read:**
  - `mem_wr_done` is pulsed in the cycle after E0+L while `mem_busy` stays 1.
  - `mem_rd_valid` is pulsed in the cycle after E0+2L.
- **ACCESS_LATENCY = 1:** a pulse in the cycle after E0+1. The minimum request spacing is 2 cycles.
- **Data hold:** `mem_rd_data` holds the last block until the next `mem_rd_valid`, and is never driven with partial data.
- **Reset mid-operation:** aborts immediately.
  - A write whose commit edge has not occurred leaves the array unchanged.
  - A queued read is dropped.
  - No done/valid pulse follows reset release.
- **Word order:** array address arithmetic is unsigned. Block word k is at address {block, k[OFS-1:0]}, so there is no wrap across blocks.

## Test plan
- **Reset behaviour:** assert `rst` = 0 in mid-WR_WAIT for a write of 0x10 to 0x389 -> all outputs 0 at once. A later read of block 0xE2 does not return 0x10 in word 1, and no `mem_wr_done` pulse follows release.
- **Four writes then a read:** write 0x389=16, 0x38A=8, 0x388=4, 0x38B=2, each issued after the previous `mem_wr_done`. Then read 0x38B -> `mem_rd_valid` 5 cycles after acceptance (L=4), `mem_rd_data` = {2, 8, 16, 4} (word3..word0).
- **Simultaneous write and read to the same block:** pulse `mem_wr_req` (0x389=100) and `mem_rd_req` (0x388) together ->
  - `mem_wr_done` at +5.
  - `mem_busy` held 1 throughout.
  - `mem_rd_valid` at +9 with word1 = 100.
- **Request while busy:** pulse `mem_wr_req` 0x2C9=200 while `mem_busy` = 1 -> ignored, array unchanged, no `mem_wr_done`.
- **Tag separation:** write 0x289=200 and 0x28A=220 (same index, tag 5), then read 0x388 -> block returns the tag-7 values {2, 120, 100, 4}, unaffected by the tag-5 writes.
- **Latency parameter:** with ACCESS_LATENCY=1, back-to-back reads at edges E0 and E0+2 -> `mem_rd_valid` pulses in the cycles after E0+1 and E0+3.
